// File: rtl/xillybus_arb_pkg.sv
// Shared constants, frame-word layout and state encoding for the host-read arbiter.
package xillybus_arb_pkg;

    localparam int IDX_W = 4;

    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam logic [7:0]  TRL_MAGIC = 8'h5A;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    localparam int MAGIC_LSB = 24;
    localparam int SRC_LSB   = 20;
    localparam int SEQ_LSB   = 12;
    localparam int CNT_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        TRL,
        DRAIN
    } arb_state_e;

    function automatic logic [31:0] hdr_word(input logic [IDX_W-1:0] src, input logic [7:0] seq);
        return (32'(HDR_MAGIC) << MAGIC_LSB) | (32'(src) << SRC_LSB) | (32'(seq) << SEQ_LSB);
    endfunction

    function automatic logic [31:0] trl_word(input logic [IDX_W-1:0] src, input logic [15:0] cnt);
        return (32'(TRL_MAGIC) << MAGIC_LSB) | (32'(src) << SRC_LSB) | (32'(cnt) << CNT_LSB);
    endfunction

endpackage

// File: rtl/xillybus_read_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter
    import xillybus_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk candidates farthest-first so the nearest requester is the last to overwrite idx.
    always_comb begin
        idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req[i] && (i == ((int'(ptr) + k) % NUM_SRC))) begin
                    idx = IDX_W'(i);
                end
            end
        end
        any = |req;
        gnt = any ? (NUM_SRC'(1) << idx) : '0;
    end

endmodule

// File: rtl/xillybus_read_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC producers into the host-read FIFO,
// framing each packet with header/trailer words and discarding data while the stream is closed.
module xillybus_read_arbiter
    import xillybus_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SEQ_W   = 8
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [32*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_last,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic                  stream_open,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [31:0]           fifo_din,
    output logic                  busy,
    output logic [15:0]           dropped_pkts
);

    arb_state_e          state_q, state_d;
    logic [NUM_SRC-1:0]  goh_q, goh_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [SEQ_W-1:0]    seq_q [NUM_SRC];
    logic [SEQ_W-1:0]    seq_d [NUM_SRC];
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         dropped_q, dropped_d;
    logic                wr_q, wr_d;
    logic [31:0]         din_q, din_d;

    logic [NUM_SRC-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                sel_valid, sel_last, ready_en, accept;
    logic [31:0]         sel_data;
    logic [SEQ_W-1:0]    sel_seq;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req (src_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_seq   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (goh_q[i]) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[32*i +: 32];
                sel_seq   = seq_q[i];
            end
        end
    end

    // DRAIN ignores fifo_full because nothing is written while draining.
    assign ready_en  = ((state_q == DATA) && stream_open && !fifo_full) || (state_q == DRAIN);
    assign src_ready = ready_en ? goh_q : '0;
    assign accept    = ready_en && sel_valid;

    always_comb begin
        state_d   = state_q;
        goh_d     = goh_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        wr_d      = 1'b0;
        din_d     = din_q;
        unique case (state_q)
            IDLE: begin
                if (stream_open && arb_any) begin
                    goh_d   = arb_gnt;
                    grant_d = arb_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!stream_open) begin
                    state_d = DRAIN;
                end else if (!fifo_full) begin
                    wr_d  = 1'b1;
                    din_d = hdr_word(grant_q, 8'(sel_seq));
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (goh_q[i]) seq_d[i] = seq_q[i] + SEQ_W'(1);
                    end
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!stream_open) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    wr_d  = 1'b1;
                    din_d = sel_data;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
                    if (sel_last) state_d = TRL;
                end
            end
            TRL: begin
                if (!fifo_full) begin
                    wr_d    = 1'b1;
                    din_d   = trl_word(grant_q, cnt_q);
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (accept && sel_last) begin
                    dropped_d = (dropped_q == CNT_MAX) ? dropped_q : dropped_q + 16'd1;
                    ptr_d     = grant_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q   <= IDLE;
            goh_q     <= '0;
            grant_q   <= '0;
            ptr_q     <= IDX_W'(NUM_SRC - 1);
            for (int i = 0; i < NUM_SRC; i++) seq_q[i] <= '0;
            cnt_q     <= '0;
            dropped_q <= '0;
            wr_q      <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            goh_q     <= goh_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            wr_q      <= wr_d;
            din_q     <= din_d;
        end
    end

    assign fifo_wr_en   = wr_q;
    assign fifo_din     = din_q;
    assign busy         = (state_q != IDLE);
    assign dropped_pkts = dropped_q;

endmodule

// File: tb/tb_xillybus_read_arbiter.sv
// Directed bench: queued producers, FIFO write recorder, hand-built expected frame streams.
module tb_xillybus_read_arbiter;

    localparam int NS = 4;

    logic              bus_clk = 1'b0;
    logic              bus_rst = 1'b1;
    logic [NS-1:0]     src_valid = '0;
    logic [32*NS-1:0]  src_data = '0;
    logic [NS-1:0]     src_last = '0;
    logic [NS-1:0]     src_ready;
    logic              stream_open = 1'b0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [31:0]       fifo_din;
    logic              busy;
    logic [15:0]       dropped_pkts;

    logic [32:0] pq [NS][$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    xillybus_read_arbiter #(.NUM_SRC(NS), .SEQ_W(8)) dut (
        .bus_clk      (bus_clk),
        .bus_rst      (bus_rst),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .stream_open  (stream_open),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .busy         (busy),
        .dropped_pkts (dropped_pkts)
    );

    always #5 bus_clk = ~bus_clk;

    // Producers: pop on handshake, present the next queued word just after the edge.
    always @(posedge bus_clk) begin
        for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        #1;
        for (int i = 0; i < NS; i++) begin
            if (pq[i].size() > 0) begin
                src_valid[i]        = 1'b1;
                src_data[32*i +: 32] = pq[i][0][31:0];
                src_last[i]         = pq[i][0][32];
            end else begin
                src_valid[i] = 1'b0;
                src_last[i]  = 1'b0;
            end
        end
    end

    always @(posedge bus_clk) begin
        if (fifo_wr_en) got.push_back(fifo_din);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] hdr(input int s, input int seq);
        return {8'hA5, 4'(s), 8'(seq), 12'h000};
    endfunction

    function automatic logic [31:0] trl(input int s, input int n);
        return {8'h5A, 4'(s), 4'h0, 16'(n)};
    endfunction

    task automatic push_pkt(input int s, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) pq[s].push_back({(k == n - 1), base + 32'(k)});
    endtask

    task automatic exp_pkt(input int s, input int seq, input int n, input logic [31:0] base);
        exp_q.push_back(hdr(s, seq));
        for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(k));
        exp_q.push_back(trl(s, n));
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < NS; i++) if (pq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge bus_clk);
            if (queues_empty() && !busy && !fifo_wr_en) break;
        end
        check({tag, "_done_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_got(input string tag, input int cnt, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            if (got.size() >= cnt) break;
            @(negedge bus_clk);
        end
        check({tag, "_got_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic compare(input string tag);
        int m;
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge bus_clk);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_wr", 32'(fifo_wr_en), 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(dropped_pkts), 32'd0);
        bus_rst = 1'b0;
        stream_open = 1'b1;
        @(negedge bus_clk);

        // Two simultaneous requesters: source 0 first, then source 2.
        push_pkt(0, 3, 32'h1000_0000);
        push_pkt(2, 3, 32'h3000_0000);
        exp_pkt(0, 0, 3, 32'h1000_0000);
        exp_pkt(2, 0, 3, 32'h3000_0000);
        wait_done("t1", 200);
        compare("t1");

        // One-word packets from source 1: sequence numbers advance.
        for (int p = 0; p < 3; p++) begin
            push_pkt(1, 1, 32'h2000_0000 + 32'(p));
            exp_pkt(1, p, 1, 32'h2000_0000 + 32'(p));
        end
        wait_done("t2", 200);
        compare("t2");

        // Back-pressure mid-DATA.
        push_pkt(3, 6, 32'h4000_0000);
        exp_pkt(3, 0, 6, 32'h4000_0000);
        wait_got("t3", 3, 100);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge bus_clk);
            check($sformatf("t3_ready%0d", k), 32'(src_ready), 32'd0);
            check($sformatf("t3_wr%0d", k), 32'(fifo_wr_en), 32'd0);
        end
        fifo_full = 1'b0;
        wait_done("t3", 200);
        compare("t3");

        // Stream closes after two payload words: rest drained, no trailer.
        push_pkt(0, 10, 32'h5000_0000);
        exp_q.push_back(hdr(0, 1));
        exp_q.push_back(32'h5000_0000);
        exp_q.push_back(32'h5000_0001);
        wait_got("t4", 2, 100);
        stream_open = 1'b0;
        wait_done("t4", 300);
        compare("t4");
        check("t4_drop", 32'(dropped_pkts), 32'd1);
        stream_open = 1'b1;
        push_pkt(0, 1, 32'h5100_0000);
        exp_pkt(0, 2, 1, 32'h5100_0000);
        wait_done("t4b", 200);
        compare("t4b");

        // Reset in the middle of a packet.
        push_pkt(2, 8, 32'h6000_0000);
        wait_got("t6", 3, 100);
        bus_rst = 1'b1;
        @(negedge bus_clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_wr", 32'(fifo_wr_en), 32'd0);
        check("t6_ready", 32'(src_ready), 32'd0);
        check("t6_drop", 32'(dropped_pkts), 32'd0);
        for (int i = 0; i < NS; i++) pq[i].delete();
        @(negedge bus_clk);
        bus_rst = 1'b0;
        got.delete();
        @(negedge bus_clk);

        // All sources requesting: order 0,1,2,3,0 with sequence counters restarted.
        push_pkt(0, 1, 32'h7000_0000);
        push_pkt(1, 1, 32'h7000_0001);
        push_pkt(2, 1, 32'h7000_0002);
        push_pkt(3, 1, 32'h7000_0003);
        push_pkt(0, 1, 32'h7000_0004);
        exp_pkt(0, 0, 1, 32'h7000_0000);
        exp_pkt(1, 0, 1, 32'h7000_0001);
        exp_pkt(2, 0, 1, 32'h7000_0002);
        exp_pkt(3, 0, 1, 32'h7000_0003);
        exp_pkt(0, 1, 1, 32'h7000_0004);
        wait_done("t5", 300);
        compare("t5");

        // Saturation of the drop counter.
        @(negedge bus_clk);
        force dut.dropped_q = 16'hFFFE;
        #1;
        release dut.dropped_q;
        for (int d = 0; d < 2; d++) begin
            stream_open = 1'b1;
            fifo_full = 1'b1;
            push_pkt(1, 2, 32'h8000_0000 + 32'(d));
            repeat (3) @(negedge bus_clk);
            stream_open = 1'b0;
            wait_done($sformatf("t5_sat%0d", d), 100);
            check($sformatf("t5_sat%0d_cnt", d), 32'(dropped_pkts), 32'h0000_FFFF);
            check($sformatf("t5_sat%0d_nowr", d), 32'(got.size()), 32'd0);
        end
        fifo_full = 1'b0;
        stream_open = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xillybus_read_arbiter.md
Name: xillybus_read_arbiter

Overview:
- Shares the single upstream 32-bit host-read stream among NUM_SRC on-chip producers.
- Writes into the FIFO whose read side feeds the core's user_r_read_32 port.
- Grants one producer per packet, round-robin. Frames each packet with a header word and a trailer word so host software can demultiplex.
- Discards producer data while the host has the stream closed.

Parameters:
- NUM_SRC, 4: number of producers, 2..16.
- SEQ_W, 8: per-source sequence counter width, fixed at 8 because of the header field.

Ports:
- bus_clk  in  1  system clock; all logic is on the rising edge.
- bus_rst  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  producer i has a word on src_data slice i.
- src_data  in  32*NUM_SRC  producer payload; slice i = bits [32i+31:32i].
- src_last  in  NUM_SRC  the current word of producer i ends its packet.
- src_ready  out  NUM_SRC  word accepted from producer i this cycle.
- stream_open  in  1  driven from user_r_read_32_open.
- fifo_full  in  1  FIFO almost-full; must assert with at least 1 free slot remaining.
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_din  out  32  FIFO write data, registered.
- busy  out  1  high in any state other than IDLE.
- dropped_pkts  out  16  count of discarded packets, saturating.

Behaviour:
- Reset values: src_ready=0, fifo_wr_en=0, fifo_din=0, busy=0, dropped_pkts=0; state=IDLE; all sequence counters=0; RR pointer=NUM_SRC-1, so source 0 has first priority.
- Transfer rule: a word transfers when src_valid[i] & src_ready[i]. Only the granted source ever sees src_ready high. src_ready is combinational from state, grant and fifo_full.
- Write timing: every FIFO write (header, payload, trailer) is registered; a decision in cycle t gives fifo_wr_en=1 in cycle t+1. Any cycle without a write has fifo_wr_en=0. Hence the required 1-slot margin on fifo_full.
- Header word: [31:24]=8'hA5, [23:20]=source index, [19:12]=seq[src], [11:0]=0.
- Trailer word: [31:24]=8'h5A, [23:20]=source index, [19:16]=0, [15:0]=payload word count. The count includes the last word and saturates at 16'hFFFF.
- States:
  - IDLE: if stream_open and any src_valid, pick the first requester after the RR pointer (wrapping), latch the grant, then go to HDR. Otherwise stay in IDLE.
  - HDR: if !stream_open, go to DRAIN. Else if !fifo_full, write the header, increment seq[grant] (wraps 8'hFF to 8'h00), clear the word count, go to DATA. Else stall.
  - DATA: if !stream_open, go to DRAIN; src_ready stays 0 in the cycle stream_open is seen low. Else src_ready[grant] = !fifo_full. Each accepted word is written and counted. Accepting with src_last high moves to TRL.
  - TRL: if !fifo_full, write the trailer, set RR pointer = grant, go to IDLE. The trailer is written even if stream_open has dropped.
  - DRAIN: src_ready[grant]=1 regardless of fifo_full; no FIFO writes. Accepting with src_last high increments dropped_pkts (saturating), sets RR pointer = grant, and returns to IDLE.
- Packet scope: a one-word packet (first word has last=1) yields header, word, trailer. Back-to-back packets from one source still go through IDLE, costing 1 idle cycle per packet.
- Simultaneous events: stream_open low and src_last in the same DATA cycle gives DRAIN, and the word is not accepted. The grant never changes mid-packet.
- Mid-operation reset: bus_rst aborts any state to IDLE on the next edge. Partial packets are not completed and the FIFO is not written in that cycle. Producers must tolerate losing a packet.

Decomposition:
- Package xillybus_arb_pkg holds:
  - HDR_MAGIC=8'hA5 and TRL_MAGIC=8'h5A;
  - the header/trailer field offsets;
  - the state enum {IDLE, HDR, DATA, TRL, DRAIN};
  - CNT_MAX=16'hFFFF.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are the request vector and pointer; outputs are a one-hot grant, the grant index and an any-request flag.

Test Plan:
- Sources 0 and 2 each offer a 3-word packet at once, stream_open=1, FIFO never full. FIFO must receive A5000000, s0 words, 5A000003, then A5200000, s2 words, 5A200003.
- Source 1 sends three 1-word packets. The headers must show seq 00, 01, 02 in bits [19:12], and each trailer count must be 0001.
- fifo_full held high for 5 cycles mid-DATA. src_ready must be 0 for those cycles, no write may occur, and no data may be lost or duplicated; final count must equal the words sent.
- stream_open deasserted after 2 of 10 payload words. Remaining 8 words must be drained without writes, no trailer written, dropped_pkts=1; the next packet must start with a fresh header.
- All 4 sources continuously valid with 1-word packets. Grant order must be 0,1,2,3,0; dropped_pkts forced near FFFF must saturate at FFFF.
- bus_rst pulsed during DATA. The next cycle must show IDLE with busy=0, fifo_wr_en=0 and seq counters reset; the first new grant must go to source 0.
